// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: frame FSM states, prefix bytes,
// the key codes the cursor logic consumes, and the decoded key-event word.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;

  // Cursor keys arrive E0-prefixed; space is a plain make code.
  localparam logic [7:0] PS2_KEY_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_KEY_RIGHT = 8'h74;
  localparam logic [7:0] PS2_KEY_SPACE = 8'h29;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_scancode_receiver_sync_filter.sv
// Brings the raw PS/2 pins into the Clock domain, deglitches the PS/2 clock and
// emits a one-cycle falling-edge strobe together with the data bit sampled alongside it.
module ps2_sync_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic iPS2_CLK,
  input  logic iPS2_DATA,
  output logic fall,
  output logic data_bit
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // Filtered level flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fall        <= 1'b0;
      data_bit    <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], iPS2_CLK};
      data_sync_q <= {data_sync_q[0], iPS2_DATA};
      data_bit    <= data_sync_q[1];
      fall        <= 1'b0;
      if (clk_sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        cnt_q  <= '0;
        filt_q <= clk_sync_q[1];
        fall   <= filt_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: frames bits on filtered clock falls, folds E0/F0 prefixes
// into tagged key-event words and buffers them in a show-ahead FIFO.
module ps2_scancode_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DATA,
  input  logic       iPop,
  output logic       oValid,
  output logic [7:0] oScanCode,
  output logic       oBreak,
  output logic       oExtended,
  output logic       oFrameError,
  output logic       oOverflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic fall;
  logic data_bit;

  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sync (
    .Clock    (Clock),
    .Reset    (Reset),
    .iPS2_CLK (iPS2_CLK),
    .iPS2_DATA(iPS2_DATA),
    .fall     (fall),
    .data_bit (data_bit)
  );

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          good_c;
  logic          err_c;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
    end
  end

  // Frame sequencing; the stop-bit fall judges the frame, the watchdog aborts stalled ones.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_d     = '0;
    good_c    = 1'b0;
    err_c     = 1'b0;

    if (state_q != ST_IDLE && !fall) tmo_d = tmo_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        if (fall && !data_bit) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          parity_d = data_bit;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (data_bit && ((^shift_q) ^ parity_q)) good_c = 1'b1;
          else                                     err_c  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = ST_IDLE;
      tmo_d   = '0;
      err_c   = 1'b1;
    end
  end

  logic       ext_pend_q;
  logic       brk_pend_q;
  logic       wr_q;
  ps2_event_t word_q;

  // Prefix bytes only arm flags; the next plain byte carries them into the FIFO.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      wr_q        <= 1'b0;
      word_q      <= '0;
      oFrameError <= 1'b0;
    end else begin
      wr_q        <= 1'b0;
      oFrameError <= err_c;
      if (err_c) begin
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end else if (good_c) begin
        if (shift_q == PS2_PREFIX_EXT) begin
          ext_pend_q <= 1'b1;
        end else if (shift_q == PS2_PREFIX_BREAK) begin
          brk_pend_q <= 1'b1;
        end else begin
          wr_q       <= 1'b1;
          word_q     <= '{ext: ext_pend_q, brk: brk_pend_q, code: shift_q};
          ext_pend_q <= 1'b0;
          brk_pend_q <= 1'b0;
        end
      end
    end
  end

  ps2_event_t    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_c;
  logic          pop_c;
  logic          push_c;

  assign full_c = (count_q == CW'(FIFO_DEPTH));
  assign pop_c  = iPop && oValid;
  assign push_c = wr_q && (!full_c || pop_c);

  always_comb begin
    count_d = count_q;
    if (push_c && !pop_c)      count_d = count_q + CW'(1);
    else if (pop_c && !push_c) count_d = count_q - CW'(1);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      oValid    <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      oOverflow <= wr_q && full_c && !pop_c;
      if (push_c) begin
        mem_q[wr_ptr_q] <= word_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      oValid  <= (count_d != '0);
    end
  end

  assign oScanCode = mem_q[rd_ptr_q].code;
  assign oBreak    = mem_q[rd_ptr_q].brk;
  assign oExtended = mem_q[rd_ptr_q].ext;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Self-checking bench for ps2_scancode_receiver: bit-bangs PS/2 frames and scores
// popped key events against a queue filled by a small prefix/FIFO model.
module tb_ps2_scancode_receiver;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned FLEN  = 8;
  localparam int unsigned TMO   = 2000;
  localparam int unsigned HALF  = 20;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       pop;
  logic       oValid;
  logic [7:0] oScanCode;
  logic       oBreak;
  logic       oExtended;
  logic       oFrameError;
  logic       oOverflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_cnt  = 0;
  int ovf_cnt  = 0;
  int exp_err  = 0;
  int exp_ovf  = 0;
  int stop_cyc = 0;
  int rise_cyc = -1;
  logic prev_valid = 1'b0;
  logic m_ext = 1'b0;
  logic m_brk = 1'b0;
  logic [9:0] exp_q[$];
  event stop_ev;

  ps2_scancode_receiver #(
    .FIFO_DEPTH    (DEPTH),
    .FILTER_LEN    (FLEN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iPS2_CLK   (ps2_clk),
    .iPS2_DATA  (ps2_data),
    .iPop       (pop),
    .oValid     (oValid),
    .oScanCode  (oScanCode),
    .oBreak     (oBreak),
    .oExtended  (oExtended),
    .oFrameError(oFrameError),
    .oOverflow  (oOverflow)
  );

  always #20 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Pulse counters and oValid rise time, sampled on the inactive edge.
  always @(negedge Clock) begin
    if (!Reset) begin
      err_cnt += int'(oFrameError);
      ovf_cnt += int'(oOverflow);
      if (oValid && !prev_valid) rise_cyc = cyc;
    end
    prev_valid = oValid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge Clock);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge Clock);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop_ok);
    logic good;
    good = par_ok && stop_ok;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par_ok ? ~(^b) : (^b));
    ps2_data = stop_ok;
    repeat (HALF) @(negedge Clock);
    ps2_clk  = 1'b0;
    stop_cyc = cyc;
    -> stop_ev;
    repeat (HALF) @(negedge Clock);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge Clock);
    if (!good) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
      else exp_ovf++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (oValid && guard < 16) begin
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected"}, 32'(oValid), 32'd0);
        break;
      end
      check({tag, "_head"}, 32'({oExtended, oBreak, oScanCode}), 32'(exp_q.pop_front()));
      pop = 1'b1;
      @(negedge Clock);
      pop = 1'b0;
      guard++;
    end
    check({tag, "_empty"}, 32'(oValid), 32'd0);
    check({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_ferr"}, 32'(err_cnt), 32'(exp_err));
    check({tag, "_ovf"}, 32'(ovf_cnt), 32'(exp_ovf));
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    pop      = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_code", 32'(oScanCode), 32'd0);
    check("rst_brk", 32'(oBreak), 32'd0);
    check("rst_ext", 32'(oExtended), 32'd0);
    check("rst_ferr", 32'(oFrameError), 32'd0);
    check("rst_ovf", 32'(oOverflow), 32'd0);
    Reset = 1'b0;
    repeat (5) @(negedge Clock);

    // Short clock glitch with data low must not be taken as a start bit.
    ps2_data = 1'b0;
    repeat (4) @(negedge Clock);
    ps2_clk = 1'b0;
    repeat (3) @(negedge Clock);
    ps2_clk = 1'b1;
    repeat (20) @(negedge Clock);
    ps2_data = 1'b1;
    repeat (20) @(negedge Clock);

    send_frame(8'h1C, 1'b1, 1'b1);
    check("make_latency", 32'(rise_cyc - stop_cyc), 32'(FLEN + 4));
    drain("make");

    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    drain("break");
    send_frame(8'hE0, 1'b1, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h74, 1'b1, 1'b1);
    drain("ext_break");

    send_frame(8'h29, 1'b0, 1'b1);
    drain("parity_bad");
    send_frame(8'h29, 1'b1, 1'b1);
    drain("parity_good");
    send_frame(8'h5A, 1'b1, 1'b0);
    drain("stop_bad");

    send_partial(8'h6B, 5);
    repeat (TMO + 100) @(negedge Clock);
    exp_err++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    check("timeout_ferr", 32'(err_cnt), 32'(exp_err));
    send_frame(8'h6B, 1'b1, 1'b1);
    drain("after_timeout");
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h29, 1'b0, 1'b1);
    send_frame(8'h6B, 1'b1, 1'b1);
    drain("err_clears_brk");

    for (int i = 0; i < 5; i++) send_frame(8'h11 + 8'(i), 1'b1, 1'b1);
    check("ovf_count", 32'(ovf_cnt), 32'(exp_ovf));
    drain("overflow");

    for (int i = 0; i < 4; i++) send_frame(8'h21 + 8'(i), 1'b1, 1'b1);
    fork
      send_frame(8'h25, 1'b1, 1'b1);
      begin
        @stop_ev;
        repeat (11) @(negedge Clock);
        check("full_pop_valid", 32'(oValid), 32'd1);
        check("full_pop_head", 32'({oExtended, oBreak, oScanCode}), 32'(exp_q.pop_front()));
        pop = 1'b1;
        @(negedge Clock);
        pop = 1'b0;
      end
    join
    drain("full_pop");

    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h12, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b1, 1'b1);
    send_partial(8'h55, 4);
    #5 Reset = 1'b1;
    #1;
    check("midrst_valid", 32'(oValid), 32'd0);
    check("midrst_code", 32'(oScanCode), 32'd0);
    check("midrst_brk", 32'(oBreak), 32'd0);
    check("midrst_ext", 32'(oExtended), 32'd0);
    check("midrst_ferr", 32'(oFrameError), 32'd0);
    check("midrst_ovf", 32'(oOverflow), 32'd0);
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    repeat (5) @(negedge Clock);
    send_frame(8'h1C, 1'b1, 1'b1);
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
